// File: rtl/cc_pkg.sv
// Shared widths and FSM state type for the Code Calculator stimulus driver.
package cc_pkg;

    localparam int unsigned CC_IN_W  = 4;
    localparam int unsigned CC_OPT_W = 3;
    localparam int unsigned CC_OUT_W = 9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_drv_score.sv
// Result scoring for cc_stim_driver: compare, vector/error counters and,
// with CC_DRV_FIRST_ERR_EN defined, first-mismatch capture.
module cc_drv_score
    import cc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                sample,
    input  logic [CC_OUT_W-1:0] got,
    input  logic [CC_OUT_W-1:0] gold,
    output logic                out_valid,
    output logic                out_pass,
    output logic [CC_OUT_W-1:0] out_got,
`ifdef CC_DRV_FIRST_ERR_EN
    output logic                fe_valid,
    output logic [CNT_W-1:0]    fe_idx,
    output logic [CC_OUT_W-1:0] fe_got,
    output logic [CC_OUT_W-1:0] fe_exp,
`endif
    output logic [CNT_W-1:0]    vec_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    logic mismatch;

    assign mismatch = (got != gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pass  <= 1'b0;
            out_got   <= '0;
        end else begin
            out_valid <= sample;
            if (sample) begin
                out_pass <= !mismatch;
                out_got  <= got;
            end
        end
    end

    // clr takes priority over a coincident result, which is then not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            vec_cnt <= '0;
            err_cnt <= '0;
        end else if (sample) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
            if (mismatch && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CC_DRV_FIRST_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_valid <= 1'b0;
            fe_idx   <= '0;
            fe_got   <= '0;
            fe_exp   <= '0;
        end else if (clr) begin
            fe_valid <= 1'b0;
            fe_idx   <= '0;
            fe_got   <= '0;
            fe_exp   <= '0;
        end else if (sample && mismatch && !fe_valid) begin
            fe_valid <= 1'b1;
            fe_idx   <= vec_cnt;
            fe_got   <= got;
            fe_exp   <= gold;
        end
    end
`endif

endmodule

// File: rtl/cc_stim_driver.sv
// Drives golden vectors onto a Code Calculator and scores its response.
// Optional first-error capture ports are enabled by defining CC_DRV_FIRST_ERR_EN.
module cc_stim_driver
    import cc_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CC_IN_W-1:0]  s_n0,
    input  logic [CC_IN_W-1:0]  s_n1,
    input  logic [CC_IN_W-1:0]  s_n2,
    input  logic [CC_IN_W-1:0]  s_n3,
    input  logic [CC_OPT_W-1:0] s_opt,
    input  logic [CC_OUT_W-1:0] s_gold,
    output logic [CC_IN_W-1:0]  cc_n0,
    output logic [CC_IN_W-1:0]  cc_n1,
    output logic [CC_IN_W-1:0]  cc_n2,
    output logic [CC_IN_W-1:0]  cc_n3,
    output logic [CC_OPT_W-1:0] cc_opt,
    input  logic [CC_OUT_W-1:0] cc_out,
    output logic                out_valid,
    output logic                out_pass,
    output logic [CC_OUT_W-1:0] out_got,
`ifdef CC_DRV_FIRST_ERR_EN
    output logic                fe_valid,
    output logic [CNT_W-1:0]    fe_idx,
    output logic [CC_OUT_W-1:0] fe_got,
    output logic [CC_OUT_W-1:0] fe_exp,
`endif
    output logic [CNT_W-1:0]    vec_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("cc_stim_driver: SETTLE_CYC must be >= 1");
    end

    cc_state_e             state_q;
    logic [SET_W-1:0]      settle_q;
    logic [CC_OUT_W-1:0]   gold_q;
    logic                  sample;

    assign in_ready = (state_q == IDLE);
    assign sample   = (state_q == DRIVE) && (settle_q == '0);

    // cc_* keep the last vector while idle so the CC inputs never glitch to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            gold_q   <= '0;
            cc_n0    <= '0;
            cc_n1    <= '0;
            cc_n2    <= '0;
            cc_n3    <= '0;
            cc_opt   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= DRIVE;
                        settle_q <= SET_W'(SETTLE_CYC - 1);
                        gold_q   <= s_gold;
                        cc_n0    <= s_n0;
                        cc_n1    <= s_n1;
                        cc_n2    <= s_n2;
                        cc_n3    <= s_n3;
                        cc_opt   <= s_opt;
                    end
                end
                DRIVE: begin
                    if (settle_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cc_drv_score #(
        .CNT_W (CNT_W)
    ) u_score (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .sample    (sample),
        .got       (cc_out),
        .gold      (gold_q),
        .out_valid (out_valid),
        .out_pass  (out_pass),
        .out_got   (out_got),
`ifdef CC_DRV_FIRST_ERR_EN
        .fe_valid  (fe_valid),
        .fe_idx    (fe_idx),
        .fe_got    (fe_got),
        .fe_exp    (fe_exp),
`endif
        .vec_cnt   (vec_cnt),
        .err_cnt   (err_cnt)
    );

endmodule

// File: tb/tb_cc_stim_driver.sv
// Bench for cc_stim_driver: three instances (settle 1 / settle 3 / 2-bit counters)
// share stimulus; cc_out is driven directly in place of a real CC.
module tb_cc_stim_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] s_n0, s_n1, s_n2, s_n3;
    logic [2:0] s_opt;
    logic [8:0] s_gold;
    logic [8:0] cc_out;

    logic        in_valid_a, in_ready_a, ov_a, op_a;
    logic [3:0]  cn_a [4];
    logic [2:0]  copt_a;
    logic [8:0]  og_a;
    logic [15:0] vec_a, err_a;

    logic        in_valid_b, in_ready_b, ov_b, op_b;
    logic [3:0]  cn_b [4];
    logic [2:0]  copt_b;
    logic [8:0]  og_b;
    logic [15:0] vec_b, err_b;

    logic        in_valid_c, in_ready_c, ov_c, op_c;
    logic [3:0]  cn_c [4];
    logic [2:0]  copt_c;
    logic [8:0]  og_c;
    logic [1:0]  vec_c, err_c;

`ifdef CC_DRV_FIRST_ERR_EN
    logic        fv_a, fv_b, fv_c;
    logic [15:0] fi_a, fi_b;
    logic [1:0]  fi_c;
    logic [8:0]  fg_a, fg_b, fg_c, fe_a, fe_b, fe_c;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cc_stim_driver #(.SETTLE_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .s_n0(s_n0), .s_n1(s_n1), .s_n2(s_n2), .s_n3(s_n3), .s_opt(s_opt), .s_gold(s_gold),
        .cc_n0(cn_a[0]), .cc_n1(cn_a[1]), .cc_n2(cn_a[2]), .cc_n3(cn_a[3]), .cc_opt(copt_a),
        .cc_out(cc_out), .out_valid(ov_a), .out_pass(op_a), .out_got(og_a),
`ifdef CC_DRV_FIRST_ERR_EN
        .fe_valid(fv_a), .fe_idx(fi_a), .fe_got(fg_a), .fe_exp(fe_a),
`endif
        .vec_cnt(vec_a), .err_cnt(err_a)
    );

    cc_stim_driver #(.SETTLE_CYC(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .s_n0(s_n0), .s_n1(s_n1), .s_n2(s_n2), .s_n3(s_n3), .s_opt(s_opt), .s_gold(s_gold),
        .cc_n0(cn_b[0]), .cc_n1(cn_b[1]), .cc_n2(cn_b[2]), .cc_n3(cn_b[3]), .cc_opt(copt_b),
        .cc_out(cc_out), .out_valid(ov_b), .out_pass(op_b), .out_got(og_b),
`ifdef CC_DRV_FIRST_ERR_EN
        .fe_valid(fv_b), .fe_idx(fi_b), .fe_got(fg_b), .fe_exp(fe_b),
`endif
        .vec_cnt(vec_b), .err_cnt(err_b)
    );

    cc_stim_driver #(.SETTLE_CYC(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .s_n0(s_n0), .s_n1(s_n1), .s_n2(s_n2), .s_n3(s_n3), .s_opt(s_opt), .s_gold(s_gold),
        .cc_n0(cn_c[0]), .cc_n1(cn_c[1]), .cc_n2(cn_c[2]), .cc_n3(cn_c[3]), .cc_opt(copt_c),
        .cc_out(cc_out), .out_valid(ov_c), .out_pass(op_c), .out_got(og_c),
`ifdef CC_DRV_FIRST_ERR_EN
        .fe_valid(fv_c), .fe_idx(fi_c), .fe_got(fg_c), .fe_exp(fe_c),
`endif
        .vec_cnt(vec_c), .err_cnt(err_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2,
                           input logic [3:0] n3, input logic [2:0] opt, input logic [8:0] gold,
                           input logic [8:0] got);
        s_n0 = n0; s_n1 = n1; s_n2 = n2; s_n3 = n3;
        s_opt = opt; s_gold = gold; cc_out = got;
    endtask

    // Accept one vector on dut_a and stop on its result cycle
    task automatic run_a();
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 8 && ov_a !== 1'b1; i++) tick();
        check("a_out_valid", 32'(ov_a), 32'd1);
    endtask

    task automatic run_c(input logic clr_at_result);
        in_valid_c = 1'b1;
        tick();
        in_valid_c = 1'b0;
        clr = clr_at_result;
        for (int i = 0; i < 8 && ov_c !== 1'b1; i++) tick();
        clr = 1'b0;
        check("c_out_valid", 32'(ov_c), 32'd1);
    endtask

    int          exp_vec, exp_err;
    logic [3:0]  r_n [4];
    logic [2:0]  r_opt;
    logic [8:0]  r_gold, r_got;
    int          acc_at [4];
    int          n_acc, n_strobe;
    logic        acc, seen_ov;
`ifdef CC_DRV_FIRST_ERR_EN
    logic        m_fe_valid;
    int          m_fe_idx;
    logic [8:0]  m_fe_got, m_fe_exp;
`endif

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        set_vec(4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 9'd0, 9'd0);

        // 1. reset state
        #2;
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_cc_n0", 32'(cn_a[0]), 32'd0);
        check("rst_cc_n3", 32'(cn_a[3]), 32'd0);
        check("rst_cc_opt", 32'(copt_a), 32'd0);
        check("rst_vec_cnt", 32'(vec_a), 32'd0);
        check("rst_err_cnt", 32'(err_a), 32'd0);
        check("rst_out_got", 32'(og_a), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 2. single matching vector, settle 1
        set_vec(4'd1, 4'd2, 4'd3, 4'd4, 3'd2, 9'h00A, 9'h00A);
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        check("t2_cc_n0", 32'(cn_a[0]), 32'd1);
        check("t2_cc_n1", 32'(cn_a[1]), 32'd2);
        check("t2_cc_n2", 32'(cn_a[2]), 32'd3);
        check("t2_cc_n3", 32'(cn_a[3]), 32'd4);
        check("t2_cc_opt", 32'(copt_a), 32'd2);
        check("t2_busy_ready", 32'(in_ready_a), 32'd0);
        check("t2_no_early_valid", 32'(ov_a), 32'd0);
        tick();
        check("t2_out_valid", 32'(ov_a), 32'd1);
        check("t2_out_pass", 32'(op_a), 32'd1);
        check("t2_ready_on_result", 32'(in_ready_a), 32'd1);
        check("t2_vec_cnt", 32'(vec_a), 32'd1);
        check("t2_err_cnt", 32'(err_a), 32'd0);
        tick();
        check("t2_valid_one_cycle", 32'(ov_a), 32'd0);
        check("t2_cc_hold", 32'(cn_a[3]), 32'd4);

        // 3. mismatch after clr
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_vec_cnt", 32'(vec_a), 32'd0);
        set_vec(4'd9, 4'd8, 4'd7, 4'd6, 3'd5, 9'h1FF, 9'h0FF);
        run_a();
        check("t3_out_pass", 32'(op_a), 32'd0);
        check("t3_out_got", 32'(og_a), 32'h0FF);
        check("t3_err_cnt", 32'(err_a), 32'd1);
        check("t3_vec_cnt", 32'(vec_a), 32'd1);
`ifdef CC_DRV_FIRST_ERR_EN
        check("t3_fe_valid", 32'(fv_a), 32'd1);
        check("t3_fe_idx", 32'(fi_a), 32'd0);
        check("t3_fe_exp", 32'(fe_a), 32'h1FF);
        check("t3_fe_got", 32'(fg_a), 32'h0FF);
        m_fe_valid = 1'b1; m_fe_idx = 0; m_fe_got = 9'h0FF; m_fe_exp = 9'h1FF;
`endif
        exp_vec = 1;
        exp_err = 1;

        // Randomized vectors on dut_a against the counting model
        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < 4; j++) r_n[j] = 4'($urandom);
            r_opt  = 3'($urandom);
            r_gold = 9'($urandom);
            r_got  = ($urandom_range(0, 1) == 0) ? r_gold : r_gold ^ 9'($urandom_range(1, 511));
            set_vec(r_n[0], r_n[1], r_n[2], r_n[3], r_opt, r_gold, r_got);
            run_a();
            check("rnd_out_pass", 32'(op_a), 32'(r_got == r_gold));
            check("rnd_out_got", 32'(og_a), 32'(r_got));
            check("rnd_cc_n2", 32'(cn_a[2]), 32'(r_n[2]));
            check("rnd_cc_opt", 32'(copt_a), 32'(r_opt));
            exp_vec = (exp_vec + 1) % 65536;
            if (r_got != r_gold && exp_err < 65535) exp_err = exp_err + 1;
            check("rnd_vec_cnt", 32'(vec_a), 32'(exp_vec));
            check("rnd_err_cnt", 32'(err_a), 32'(exp_err));
`ifdef CC_DRV_FIRST_ERR_EN
            check("rnd_fe_idx", 32'(fi_a), 32'(m_fe_idx));
            check("rnd_fe_exp", 32'(fe_a), 32'(m_fe_exp));
`endif
            tick();
        end

        // 4. back-to-back on settle 3 with in_valid held
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_acc = 0; n_strobe = 0;
        set_vec(4'd5, 4'd1, 4'd1, 4'd1, 3'd1, 9'h011, 9'h011);
        in_valid_b = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            acc = in_valid_b && in_ready_b;
            tick();
            if (acc) begin
                if (n_acc < 4) acc_at[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) set_vec(4'(5 + n_acc), 4'd1, 4'd1, 4'd1, 3'd1, 9'h011, 9'h011);
                else in_valid_b = 1'b0;
            end
            if (ov_b === 1'b1) n_strobe++;
        end
        in_valid_b = 1'b0;
        check("t4_accepts", 32'(n_acc), 32'd4);
        for (int i = 0; i < 4; i++) check("t4_accept_cycle", 32'(acc_at[i]), 32'(4 * i));
        check("t4_strobes", 32'(n_strobe), 32'd4);
        check("t4_vec_cnt", 32'(vec_b), 32'd4);
        check("t4_cc_hold", 32'(cn_b[0]), 32'd8);

        // 5. reset one cycle after accept
        tick();
        set_vec(4'd3, 4'd3, 4'd3, 4'd3, 3'd3, 9'h033, 9'h033);
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_in_ready", 32'(in_ready_b), 32'd1);
        check("t5_out_valid", 32'(ov_b), 32'd0);
        check("t5_cc_n0", 32'(cn_b[0]), 32'd0);
        check("t5_vec_cnt", 32'(vec_b), 32'd0);
        check("t5_err_cnt", 32'(err_b), 32'd0);
        tick();
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ov_b !== 1'b0) seen_ov = 1'b1;
        end
        check("t5_no_result", 32'(seen_ov), 32'd0);
        check("t5_ready_after", 32'(in_ready_b), 32'd1);

        // 6. 2-bit counters: saturate/wrap, then clr coincident with a result
        for (int k = 1; k <= 5; k++) begin
            set_vec(4'(k), 4'd0, 4'd0, 4'd0, 3'd0, 9'h100, 9'h000);
            run_c(1'b0);
            check("t6_vec_cnt", 32'(vec_c), 32'(k % 4));
            check("t6_err_cnt", 32'(err_c), 32'((k < 3) ? k : 3));
            tick();
        end
        set_vec(4'd6, 4'd0, 4'd0, 4'd0, 3'd0, 9'h000, 9'h001);
        run_c(1'b1);
        check("t6_clr_pass", 32'(op_c), 32'd0);
        check("t6_clr_vec", 32'(vec_c), 32'd0);
        check("t6_clr_err", 32'(err_c), 32'd0);
`ifdef CC_DRV_FIRST_ERR_EN
        check("t6_clr_fe_valid", 32'(fv_c), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
